// File: rtl/btn_pulse_encoder.sv
// -----------------------------------------------------------------------------
// btn_pulse_encoder
//   Front end for the 4-bit ALU / seven-segment controller. Four raw, bouncing
//   push-buttons are synchronised, debounced independently, and turned into
//   single-cycle event codes on num_o. Holding all four buttons for CLR_HOLD
//   cycles emits one 4'b1111 clear code.
//
//   Optional feature macro: BTN_AUTOREPEAT_EN
//     When defined, bits 0 (inc) and 1 (dec) auto-repeat while held as the
//     only active button: first repeat REPEAT_DELAY cycles after the press,
//     then every REPEAT_PERIOD cycles. When undefined no repeat logic exists.
//
// Ports
//   clk     : system clock
//   rst     : asynchronous, active-high reset
//   btn_i   : raw buttons (3 = cancel, 2 = next/op, 1 = dec, 0 = inc)
//   num_o   : registered one-cycle event code, 4'b0000 when idle
//   level_o : registered debounced button levels
// -----------------------------------------------------------------------------
module btn_pulse_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CLR_HOLD        = 100000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_i,
  output logic [3:0] num_o,
  output logic [3:0] level_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int CH_W = $clog2(CLR_HOLD) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CLR_HOLD - 1);

  // The hold counter starts at 1 on entry, so a hold of one cycle is meaningless.
  if (DEBOUNCE_CYCLES < 1 || CLR_HOLD < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("btn_pulse_encoder: illegal parameter value");
  end

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_COUNT = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_t;

  logic [3:0]      sync1_r;
  logic [3:0]      sync2_r;
  logic [DB_W-1:0] db_cnt_r [4];
  logic [3:0]      level_r;
  logic [3:0]      level_next_s;
  logic [3:0]      rise_s;
  logic [3:0]      rep_pulse_s;
  logic [3:0]      num_r;
  logic [3:0]      num_next_s;

  clr_state_t      clr_state_r;
  clr_state_t      clr_state_next_s;
  logic [CH_W-1:0] clr_cnt_r;
  logic            all_high_s;
  logic            all_low_s;
  logic            chord_fire_s;

  // Two-flop synchroniser per button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= btn_i;
      sync2_r <= sync1_r;
    end
  end

  // Next debounced level: a bit flips once its counter has seen a full window of disagreement.
  always_comb begin
    level_next_s = level_r;
    for (int i = 0; i < 4; i++) begin
      if ((sync2_r[i] != level_r[i]) && (db_cnt_r[i] == DB_LAST)) begin
        level_next_s[i] = ~level_r[i];
      end else begin
        level_next_s[i] = level_r[i];
      end
    end
  end

  // Per-bit debounce counters and the debounced level register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= '0;
      end
      level_r <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == level_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
        end
      end
      level_r <= level_next_s;
    end
  end

  // Press detection: registered alongside level_r, so the pulse and the new level appear together.
  always_comb begin
    rise_s     = level_next_s & ~level_r;
    all_high_s = (level_r == 4'b1111);
    all_low_s  = (level_r == 4'b0000);
  end

  // Clear-chord state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_state_r <= CLR_IDLE;
    end else begin
      clr_state_r <= clr_state_next_s;
    end
  end

  // Hold counter: the cycle that enters CLR_COUNT already counts as the first held cycle,
  // so the clear code lands exactly CLR_HOLD cycles after the levels all went high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt_r <= '0;
    end else begin
      case (clr_state_r)
        CLR_IDLE: begin
          if (all_high_s) begin
            clr_cnt_r <= CH_W'(1);
          end else begin
            clr_cnt_r <= '0;
          end
        end
        CLR_COUNT: begin
          if (!all_high_s || chord_fire_s) begin
            clr_cnt_r <= '0;
          end else begin
            clr_cnt_r <= clr_cnt_r + CH_W'(1);
          end
        end
        default: clr_cnt_r <= '0;
      endcase
    end
  end

  // Clear-chord next-state logic.
  always_comb begin
    clr_state_next_s = clr_state_r;
    case (clr_state_r)
      CLR_IDLE: begin
        if (all_high_s) begin
          clr_state_next_s = CLR_COUNT;
        end else begin
          clr_state_next_s = CLR_IDLE;
        end
      end
      CLR_COUNT: begin
        if (!all_high_s) begin
          clr_state_next_s = CLR_IDLE;
        end else if (clr_cnt_r == CH_LAST) begin
          clr_state_next_s = CLR_DONE;
        end else begin
          clr_state_next_s = CLR_COUNT;
        end
      end
      CLR_DONE: begin
        if (all_low_s) begin
          clr_state_next_s = CLR_IDLE;
        end else begin
          clr_state_next_s = CLR_DONE;
        end
      end
      default: clr_state_next_s = CLR_IDLE;
    endcase
  end

  // Clear-chord output decode.
  always_comb begin
    chord_fire_s = 1'b0;
    case (clr_state_r)
      CLR_COUNT: begin
        if (all_high_s && (clr_cnt_r == CH_LAST)) begin
          chord_fire_s = 1'b1;
        end else begin
          chord_fire_s = 1'b0;
        end
      end
      default: chord_fire_s = 1'b0;
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX) + 1;
  localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 1);

  logic            rep_en_r;
  logic            rep_first_r;
  logic            rep_bit_r;
  logic [RP_W-1:0] rep_cnt_r;
  logic [3:0]      rep_code_s;
  logic            rep_hold_s;
  logic [RP_W-1:0] rep_last_s;

  // Repeat continues only while the pressed bit stays the sole debounced level
  // (judged on the next level, so a release or another rise stops it at once).
  always_comb begin
    rep_code_s = rep_bit_r ? 4'b0010 : 4'b0001;
    rep_hold_s = rep_en_r && (level_next_s == rep_code_s);
    rep_last_s = rep_first_r ? RD_LAST : RP_LAST;
    if (rep_hold_s && (rep_cnt_r == rep_last_s)) begin
      rep_pulse_s = rep_code_s;
    end else begin
      rep_pulse_s = 4'b0000;
    end
  end

  // Repeat arming and interval counter; armed only by a press that leaves that bit alone high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_en_r    <= 1'b0;
      rep_first_r <= 1'b0;
      rep_bit_r   <= 1'b0;
      rep_cnt_r   <= '0;
    end else if (rise_s[0] && (level_next_s == 4'b0001)) begin
      rep_en_r    <= 1'b1;
      rep_first_r <= 1'b1;
      rep_bit_r   <= 1'b0;
      rep_cnt_r   <= '0;
    end else if (rise_s[1] && (level_next_s == 4'b0010)) begin
      rep_en_r    <= 1'b1;
      rep_first_r <= 1'b1;
      rep_bit_r   <= 1'b1;
      rep_cnt_r   <= '0;
    end else if (rep_hold_s) begin
      if (rep_pulse_s != 4'b0000) begin
        rep_cnt_r   <= '0;
        rep_first_r <= 1'b0;
      end else begin
        rep_cnt_r   <= rep_cnt_r + RP_W'(1);
      end
    end else begin
      rep_en_r    <= 1'b0;
      rep_first_r <= 1'b0;
      rep_cnt_r   <= '0;
    end
  end
`else
  assign rep_pulse_s = 4'b0000;
`endif

  // Event code: the clear chord wins over any coincident press or repeat pulse.
  always_comb begin
    if (chord_fire_s) begin
      num_next_s = 4'b1111;
    end else begin
      num_next_s = rise_s | rep_pulse_s;
    end
  end

  // Registered event output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_r <= 4'b0000;
    end else begin
      num_r <= num_next_s;
    end
  end

  assign num_o   = num_r;
  assign level_o = level_r;

endmodule

// File: tb/tb_btn_pulse_encoder.sv
// -----------------------------------------------------------------------------
// tb_btn_pulse_encoder
//   Self-checking bench for btn_pulse_encoder with small parameters. A
//   behavioural model (history of raw samples, "last D synchronised samples
//   disagree" debounce rule, chord run length, repeat due times) predicts
//   level_o and num_o every cycle. Directed scenarios add pulse-count and
//   latency checks. Honours BTN_AUTOREPEAT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_btn_pulse_encoder;

  localparam int D  = 4;
  localparam int H  = 8;
  localparam int RD = 6;
  localparam int RP = 3;

  logic       clk;
  logic       rst;
  logic [3:0] btn_i;
  logic [3:0] num_o;
  logic [3:0] level_o;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  btn_pulse_encoder #(
    .DEBOUNCE_CYCLES(D),
    .CLR_HOLD(H),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_i(btn_i),
    .num_o(num_o),
    .level_o(level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [3:0] samp[$];
  logic [3:0] m_lvl;
  int         m_run;
  bit         m_armed;
  int         m_edge;
  bit         m_rep_on;
  int         m_rep_bit;
  int         m_rep_due;

  task automatic m_reset();
    samp.delete();
    for (int i = 0; i < D + 2; i++) samp.push_back(4'b0000);
    m_lvl     = 4'b0000;
    m_run     = 0;
    m_armed   = 1'b1;
    m_edge    = 0;
    m_rep_on  = 1'b0;
    m_rep_bit = 0;
    m_rep_due = 0;
  endtask

  task automatic m_step(input logic [3:0] b, output logic [3:0] e_lvl, output logic [3:0] e_num);
    logic [3:0] old_l;
    logic [3:0] new_l;
    logic [3:0] rise;
    logic [3:0] rep;
    logic [3:0] s;
    bit         fire;
    bit         all_diff;
    samp.push_back(b);
    while (samp.size() > D + 2) void'(samp.pop_front());
    m_edge++;
    old_l = m_lvl;
    new_l = old_l;
    // the synchronised sample seen at this edge is the raw sample from two edges ago
    for (int i = 0; i < 4; i++) begin
      all_diff = 1'b1;
      for (int k = 0; k < D; k++) begin
        s = samp[samp.size() - 3 - k];
        if (s[i] == old_l[i]) all_diff = 1'b0;
      end
      if (all_diff) new_l[i] = ~old_l[i];
    end
    rise = new_l & ~old_l;
    if (old_l == 4'b1111) m_run++;
    else m_run = 0;
    if (old_l == 4'b0000) m_armed = 1'b1;
    fire = m_armed && (m_run == H);
    if (fire) m_armed = 1'b0;
    rep = 4'b0000;
`ifdef BTN_AUTOREPEAT_EN
    if (rise[0] && new_l == 4'b0001) begin
      m_rep_on = 1'b1; m_rep_bit = 0; m_rep_due = m_edge + RD;
    end else if (rise[1] && new_l == 4'b0010) begin
      m_rep_on = 1'b1; m_rep_bit = 1; m_rep_due = m_edge + RD;
    end else if (m_rep_on) begin
      if (new_l != (4'b0001 << m_rep_bit)) begin
        m_rep_on = 1'b0;
      end else if (m_edge == m_rep_due) begin
        rep = 4'b0001 << m_rep_bit;
        m_rep_due = m_edge + RP;
      end
    end
`endif
    e_num = fire ? 4'b1111 : (rise | rep);
    m_lvl = new_l;
    e_lvl = new_l;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (model edge %0d)", tag, obs, exp, m_edge);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] b);
    logic [3:0] el;
    logic [3:0] en;
    btn_i = b;
    @(posedge clk);
    m_step(b, el, en);
    #1;
    chk("level_o", level_o, el);
    chk("num_o", num_o, en);
  endtask

  // Hold b for n cycles; count cycles where num_o equals code and note the first one (1-based).
  task automatic run_count(input logic [3:0] b, input int n, input logic [3:0] code,
                           output int cnt, output int first_at);
    cnt = 0;
    first_at = -1;
    for (int i = 1; i <= n; i++) begin
      step(b);
      if (num_o === code) begin
        cnt++;
        if (first_at < 0) first_at = i;
      end
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_level", level_o, 4'b0000);
    chk("rst_num", num_o, 4'b0000);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int c2;
    int f;
    int len;
    logic [3:0] b;

    rst   = 1'b1;
    btn_i = 4'b0000;
    #3;
    chk("reset_level", level_o, 4'b0000);
    chk("reset_num", num_o, 4'b0000);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // clean press: one pulse at step 6, none on release
    run_count(4'b0001, 10, 4'b0001, c, f);
    chk_int("clean_count", c, 1);
    chk_int("clean_latency", f, 6);
    run_count(4'b0000, 10, 4'b0001, c, f);
    chk_int("clean_release", c, 0);

    // bounce on bit 2, then settle high
    step(4'b0100); step(4'b0000); step(4'b0100); step(4'b0000);
    run_count(4'b0100, 10, 4'b0100, c, f);
    chk_int("bounce_count", c, 1);
    chk_int("bounce_latency", f, 6);
    run_count(4'b0000, 10, 4'b0100, c, f);
    chk_int("bounce_release", c, 0);

    // simultaneous rises give one OR-ed code
    run_count(4'b0011, 10, 4'b0011, c, f);
    chk_int("simul_count", c, 1);
    run_count(4'b0000, 10, 4'b0011, c, f);

    // full chord: OR-ed press code plus one clear code, nothing more while held
    run_count(4'b1111, 20, 4'b1111, c, f);
    chk_int("chord_count", c, 2);
    run_count(4'b0000, 10, 4'b1111, c, f);
    // chord broken before the hold completes: only the press code
    run_count(4'b1111, 6, 4'b1111, c, f);
    run_count(4'b1110, 12, 4'b1111, c2, f);
    chk_int("chord_abort_count", c + c2, 1);
    run_count(4'b0000, 10, 4'b1111, c, f);

    // reset mid-debounce, button held through release
    step(4'b0010); step(4'b0010);
    do_reset();
    run_count(4'b0010, 10, 4'b0010, c, f);
    chk_int("rst_mid_count", c, 1);
    chk_int("rst_mid_latency", f, 6);
    // reset with the level high: fresh press afterwards
    do_reset();
    run_count(4'b0010, 10, 4'b0010, c, f);
    chk_int("rst_held_count", c, 1);
    chk_int("rst_held_latency", f, 6);
    run_count(4'b0000, 10, 4'b0010, c, f);

    // auto-repeat on bit 0
    run_count(4'b0001, 26, 4'b0001, c, f);
`ifdef BTN_AUTOREPEAT_EN
    chk_int("repeat_count", c, 6);
`else
    chk_int("repeat_count", c, 1);
`endif
    chk_int("repeat_first", f, 6);
    run_count(4'b0000, 10, 4'b0001, c, f);

    // randomized segments: bouncy short holds, long holds, chords, occasional resets
    for (int seg = 0; seg < 80; seg++) begin
      case ($urandom_range(0, 5))
        0: b = 4'b1111;
        1: b = 4'b0001 << $urandom_range(0, 1);
        default: b = 4'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 2) == 0) len = $urandom_range(1, 3);
      else len = $urandom_range(4, 16);
      for (int i = 0; i < len; i++) step(b);
      if ($urandom_range(0, 19) == 0) do_reset();
    end
    for (int i = 0; i < 12; i++) step(4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
